// File: rtl/sha3_pkg.sv
// Shared SHA3 front-end definitions: mode encoding, rate/digest
// lookups and padding constants.
package sha3_pkg;

    typedef enum logic [1:0] {
        MODE_224 = 2'd0,
        MODE_256 = 2'd1,
        MODE_384 = 2'd2,
        MODE_512 = 2'd3
    } sha3_mode_e;

    localparam int MAX_RATE       = 1152;
    localparam int MAX_RATE_BYTES = MAX_RATE / 8;

    localparam logic [7:0] PAD_FIRST = 8'h06;
    localparam logic [7:0] PAD_LAST  = 8'h80;

    // Rate of the sponge in bytes for a given mode.
    function automatic logic [7:0] rate_bytes(input logic [1:0] mode);
        logic [7:0] r;
        case (sha3_mode_e'(mode))
            MODE_224: r = 8'd144;
            MODE_256: r = 8'd136;
            MODE_384: r = 8'd104;
            default:  r = 8'd72;
        endcase
        return r;
    endfunction

    // Digest length in bits for a given mode.
    function automatic logic [9:0] digest_bits(input logic [1:0] mode);
        logic [9:0] d;
        case (sha3_mode_e'(mode))
            MODE_224: d = 10'd224;
            MODE_256: d = 10'd256;
            MODE_384: d = 10'd384;
            default:  d = 10'd512;
        endcase
        return d;
    endfunction

endpackage

// File: rtl/sha3_digest_serializer.sv
// Captures one digest from the core and streams it out as an
// AXI-Stream packet, LSB word first, with a trimmed final keep.
module sha3_digest_serializer
    import sha3_pkg::*;
#(
    parameter  int WIDTH = 16,
    localparam int KW    = WIDTH / 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [511:0]     dig_data,
    input  logic [1:0]       dig_mode,
    input  logic             dig_valid,
    output logic             dig_ready,
    output logic [WIDTH-1:0] m_tdata,
    output logic [KW-1:0]    m_tkeep,
    output logic             m_tlast,
    output logic             m_tvalid,
    input  logic             m_tready
);

    logic         live_q;
    logic         full_q, full_d;
    logic [6:0]   beat_q, beat_d;
    logic [511:0] data_q, data_d;
    logic [1:0]   mode_q, mode_d;

    logic [9:0]   dbits;
    logic [31:0]  rem_bits;
    logic [31:0]  rem_bytes;
    logic [6:0]   nlast;
    logic [KW-1:0] last_keep;
    logic         is_last;
    logic         capture;

    // Beat count and final keep derived from the captured mode.
    always_comb begin
        dbits     = digest_bits(mode_q);
        nlast     = 7'((32'(dbits) + WIDTH - 1) / WIDTH - 1);
        rem_bits  = 32'(dbits) % WIDTH;
        rem_bytes = rem_bits / 8;
        last_keep = (rem_bits == 32'd0) ? {KW{1'b1}}
                                        : KW'((1 << rem_bytes) - 1);
    end

    assign is_last   = full_q && (beat_q == nlast);
    assign dig_ready = live_q && !full_q;
    assign capture   = dig_valid && dig_ready;
    assign m_tvalid  = full_q;
    assign m_tdata   = data_q[WIDTH-1:0];
    assign m_tlast   = is_last;
    assign m_tkeep   = !full_q ? '0 : (is_last ? last_keep : {KW{1'b1}});

    // Capture a digest when empty, shift one word out per accepted beat.
    always_comb begin
        full_d = full_q;
        beat_d = beat_q;
        data_d = data_q;
        mode_d = mode_q;
        if (capture) begin
            full_d = 1'b1;
            beat_d = 7'd0;
            data_d = dig_data;
            mode_d = dig_mode;
        end else if (full_q && m_tready) begin
            data_d = data_q >> WIDTH;
            if (is_last) begin
                full_d = 1'b0;
            end else begin
                beat_d = beat_q + 7'd1;
            end
        end
    end

    // State registers; live_q holds off ready until reset is released.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            live_q <= 1'b0;
            full_q <= 1'b0;
            beat_q <= 7'd0;
            data_q <= '0;
            mode_q <= 2'd0;
        end else begin
            live_q <= 1'b1;
            full_q <= full_d;
            beat_q <= beat_d;
            data_q <= data_d;
            mode_q <= mode_d;
        end
    end

endmodule

// File: rtl/sha3_axis_frontend.sv
// AXI-Stream front end for the Keccak core: packs words into rate
// blocks, applies SHA3 padding and serialises the digest.
module sha3_axis_frontend
    import sha3_pkg::*;
#(
    parameter  int WIDTH = 16,
    localparam int KW    = WIDTH / 8
) (
    input  logic             ACLK,
    input  logic             ARESET,
    input  logic [WIDTH-1:0] s_tdata,
    input  logic [KW-1:0]    s_tkeep,
    input  logic [1:0]       s_tuser,
    input  logic             s_tlast,
    input  logic             s_tvalid,
    output logic             s_tready,
    output logic [1151:0]    blk_data,
    output logic [1:0]       blk_mode,
    output logic             blk_first,
    output logic             blk_last,
    output logic             blk_valid,
    input  logic             blk_ready,
    input  logic [511:0]     dig_data,
    input  logic [1:0]       dig_mode,
    input  logic             dig_valid,
    output logic             dig_ready,
    output logic [WIDTH-1:0] m_tdata,
    output logic [KW-1:0]    m_tkeep,
    output logic             m_tlast,
    output logic             m_tvalid,
    input  logic             m_tready
);

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_FILL = 2'd1;
    localparam logic [1:0] ST_PAD  = 2'd2;
    localparam logic [1:0] ST_SEND = 2'd3;

    logic                live_q;
    logic [1:0]          state_q, state_d;
    logic [7:0]          widx_q, widx_d;
    logic [MAX_RATE-1:0] buf_q, buf_d;
    logic [1:0]          mode_q, mode_d;
    logic                first_q, first_d;
    logic                last_q, last_d;
    logic                padp_q, padp_d;
    logic [7:0]          b_q, b_d;

    logic                accept;
    logic [1:0]          mode_sel;
    logic [7:0]          rate_sel;
    logic [7:0]          rate_q;
    logic [7:0]          rw_last;
    logic [7:0]          widx_cur;
    logic [10:0]         wbase;
    logic [7:0]          nkeep;
    logic [7:0]          b_new;
    logic [WIDTH-1:0]    wmask;

    assign s_tready  = live_q && (state_q == ST_IDLE || state_q == ST_FILL);
    assign accept    = s_tvalid && s_tready;
    assign blk_valid = (state_q == ST_SEND);
    assign blk_first = blk_valid && first_q;
    assign blk_last  = blk_valid && last_q;
    assign blk_data  = buf_q;
    assign blk_mode  = mode_q;

    // Word placement, byte masking and end-of-message position.
    always_comb begin
        mode_sel = (state_q == ST_IDLE) ? s_tuser : mode_q;
        rate_sel = rate_bytes(mode_sel);
        rate_q   = rate_bytes(mode_q);
        rw_last  = rate_sel / 8'(KW) - 8'd1;
        widx_cur = (state_q == ST_IDLE) ? 8'd0 : widx_q;
        wbase    = 11'(widx_cur * WIDTH);
        nkeep    = 8'd0;
        wmask    = s_tdata;
        for (int i = 0; i < KW; i++) begin
            nkeep = nkeep + {7'd0, s_tkeep[i]};
            if (s_tlast && !s_tkeep[i]) begin
                wmask[8*i +: 8] = 8'h00;
            end
        end
        b_new = 8'(widx_cur * KW) + nkeep;
    end

    // Absorb FSM: fill, pad and hand blocks to the core.
    always_comb begin
        state_d = state_q;
        widx_d  = widx_q;
        buf_d   = buf_q;
        mode_d  = mode_q;
        first_d = first_q;
        last_d  = last_q;
        padp_d  = padp_q;
        b_d     = b_q;
        if (accept) begin
            if (state_q == ST_IDLE) begin
                mode_d  = s_tuser;
                first_d = 1'b1;
                padp_d  = 1'b0;
                buf_d   = '0;
            end
            buf_d[wbase +: WIDTH] = wmask;
            if (s_tlast) begin
                b_d = b_new;
                if (b_new == rate_sel) begin
                    state_d = ST_SEND;
                    last_d  = 1'b0;
                    padp_d  = 1'b1;
                end else begin
                    state_d = ST_PAD;
                end
            end else if (widx_cur == rw_last) begin
                state_d = ST_SEND;
                last_d  = 1'b0;
                widx_d  = 8'd0;
            end else begin
                state_d = ST_FILL;
                widx_d  = widx_cur + 8'd1;
            end
        end
        case (state_q)
            ST_PAD: begin
                for (int i = 0; i < MAX_RATE_BYTES; i++) begin
                    if (8'(i) >= b_q) begin
                        buf_d[8*i +: 8] = 8'h00;
                    end
                    if (8'(i) == b_q) begin
                        buf_d[8*i +: 8] = buf_d[8*i +: 8] | PAD_FIRST;
                    end
                    if (8'(i) == rate_q - 8'd1) begin
                        buf_d[8*i +: 8] = buf_d[8*i +: 8] | PAD_LAST;
                    end
                end
                state_d = ST_SEND;
                last_d  = 1'b1;
            end
            ST_SEND: begin
                if (blk_ready) begin
                    first_d = 1'b0;
                    if (padp_q) begin
                        buf_d   = '0;
                        b_d     = 8'd0;
                        padp_d  = 1'b0;
                        state_d = ST_PAD;
                    end else if (last_q) begin
                        state_d = ST_IDLE;
                    end else begin
                        state_d = ST_FILL;
                        widx_d  = 8'd0;
                    end
                end
            end
            default: ;
        endcase
    end

    // Absorb state registers; live_q holds off ready until reset is released.
    always_ff @(posedge ACLK or posedge ARESET) begin
        if (ARESET) begin
            live_q  <= 1'b0;
            state_q <= ST_IDLE;
            widx_q  <= 8'd0;
            buf_q   <= '0;
            mode_q  <= 2'd0;
            first_q <= 1'b0;
            last_q  <= 1'b0;
            padp_q  <= 1'b0;
            b_q     <= 8'd0;
        end else begin
            live_q  <= 1'b1;
            state_q <= state_d;
            widx_q  <= widx_d;
            buf_q   <= buf_d;
            mode_q  <= mode_d;
            first_q <= first_d;
            last_q  <= last_d;
            padp_q  <= padp_d;
            b_q     <= b_d;
        end
    end

    sha3_digest_serializer #(
        .WIDTH (WIDTH)
    ) u_ser (
        .clk       (ACLK),
        .rst       (ARESET),
        .dig_data  (dig_data),
        .dig_mode  (dig_mode),
        .dig_valid (dig_valid),
        .dig_ready (dig_ready),
        .m_tdata   (m_tdata),
        .m_tkeep   (m_tkeep),
        .m_tlast   (m_tlast),
        .m_tvalid  (m_tvalid),
        .m_tready  (m_tready)
    );

endmodule

// File: tb/tb_sha3_axis_frontend.sv
// Directed bench for sha3_axis_frontend: padding blocks, backpressure,
// digest serialisation at 16 and 64 bits, and reset mid-message.
module tb_sha3_axis_frontend;

    logic ACLK = 1'b0;
    logic ARESET;
    always #5 ACLK = ~ACLK;

    logic [15:0]   s_tdata;
    logic [1:0]    s_tkeep;
    logic [1:0]    s_tuser;
    logic          s_tlast, s_tvalid, s_tready;
    logic [1151:0] blk_data;
    logic [1:0]    blk_mode;
    logic          blk_first, blk_last, blk_valid, blk_ready;
    logic [511:0]  dig_data;
    logic [1:0]    dig_mode;
    logic          dig_valid, dig_ready;
    logic [15:0]   m_tdata;
    logic [1:0]    m_tkeep;
    logic          m_tlast, m_tvalid, m_tready;

    logic [63:0]   x_tdata;
    logic [7:0]    x_tkeep;
    logic          x_tready;
    logic [1151:0] x_blk_data;
    logic [1:0]    x_blk_mode;
    logic          x_blk_first, x_blk_last, x_blk_valid;
    logic [511:0]  x_dig_data;
    logic [1:0]    x_dig_mode;
    logic          x_dig_valid, x_dig_ready;
    logic [63:0]   x_m_tdata;
    logic [7:0]    x_m_tkeep;
    logic          x_m_tlast, x_m_tvalid, x_m_tready;

    sha3_axis_frontend #(.WIDTH(16)) dut (
        .ACLK(ACLK), .ARESET(ARESET),
        .s_tdata(s_tdata), .s_tkeep(s_tkeep), .s_tuser(s_tuser),
        .s_tlast(s_tlast), .s_tvalid(s_tvalid), .s_tready(s_tready),
        .blk_data(blk_data), .blk_mode(blk_mode), .blk_first(blk_first),
        .blk_last(blk_last), .blk_valid(blk_valid), .blk_ready(blk_ready),
        .dig_data(dig_data), .dig_mode(dig_mode), .dig_valid(dig_valid),
        .dig_ready(dig_ready), .m_tdata(m_tdata), .m_tkeep(m_tkeep),
        .m_tlast(m_tlast), .m_tvalid(m_tvalid), .m_tready(m_tready)
    );

    sha3_axis_frontend #(.WIDTH(64)) dut64 (
        .ACLK(ACLK), .ARESET(ARESET),
        .s_tdata(x_tdata), .s_tkeep(x_tkeep), .s_tuser(2'd0),
        .s_tlast(1'b0), .s_tvalid(1'b0), .s_tready(x_tready),
        .blk_data(x_blk_data), .blk_mode(x_blk_mode), .blk_first(x_blk_first),
        .blk_last(x_blk_last), .blk_valid(x_blk_valid), .blk_ready(1'b1),
        .dig_data(x_dig_data), .dig_mode(x_dig_mode), .dig_valid(x_dig_valid),
        .dig_ready(x_dig_ready), .m_tdata(x_m_tdata), .m_tkeep(x_m_tkeep),
        .m_tlast(x_m_tlast), .m_tvalid(x_m_tvalid), .m_tready(x_m_tready)
    );

    typedef struct {
        logic [1151:0] data;
        logic [1:0]    mode;
        logic          first;
        logic          last;
    } blk_t;

    blk_t        blks[$];
    logic [15:0] bd[$];
    logic [1:0]  bk[$];
    logic        bl[$];
    logic [63:0] xd[$];
    logic [7:0]  xk[$];
    logic        xl[$];

    int checks = 0;
    int errors = 0;
    logic [7:0] msg [0:143];

    // Record every completed handshake on the block and digest ports.
    always @(posedge ACLK) begin : mon
        blk_t t;
        if (!ARESET) begin
            if (blk_valid && blk_ready) begin
                t.data  = blk_data;
                t.mode  = blk_mode;
                t.first = blk_first;
                t.last  = blk_last;
                blks.push_back(t);
            end
            if (m_tvalid && m_tready) begin
                bd.push_back(m_tdata);
                bk.push_back(m_tkeep);
                bl.push_back(m_tlast);
            end
            if (x_m_tvalid && x_m_tready) begin
                xd.push_back(x_m_tdata);
                xk.push_back(x_m_tkeep);
                xl.push_back(x_m_tlast);
            end
        end
    end

    function automatic logic [1151:0] exp_block(input int len, input int rate,
                                                input bit pad);
        logic [1151:0] e;
        e = '0;
        for (int i = 0; i < len; i++) e[8*i +: 8] = msg[i];
        if (pad) begin
            e[8*len +: 8]      = e[8*len +: 8] | 8'h06;
            e[8*(rate-1) +: 8] = e[8*(rate-1) +: 8] | 8'h80;
        end
        return e;
    endfunction

    function automatic int first_diff(input logic [1151:0] a,
                                      input logic [1151:0] b);
        for (int i = 0; i < 144; i++)
            if (a[8*i +: 8] !== b[8*i +: 8]) return i;
        return 0;
    endfunction

    task automatic push(input logic [15:0] d, input logic [1:0] k,
                        input logic [1:0] u, input logic l);
        int n;
        @(negedge ACLK);
        s_tdata = d; s_tkeep = k; s_tuser = u; s_tlast = l; s_tvalid = 1'b1;
        n = 0;
        while (!s_tready && n < 100) begin
            @(negedge ACLK);
            n++;
        end
        if (!s_tready) begin
            checks++; errors++;
            $display("FAIL push_timeout s_tready=%0b required 1", s_tready);
        end
        @(posedge ACLK);
    endtask

    task automatic idle_in();
        @(negedge ACLK);
        s_tvalid = 1'b0; s_tlast = 1'b0; s_tkeep = 2'b00;
    endtask

    task automatic send_msg(input int len, input logic [1:0] mode);
        int nw;
        logic [15:0] d;
        logic [1:0] k, u;
        logic l;
        if (len == 0) begin
            push(16'h0000, 2'b00, mode, 1'b1);
        end else begin
            nw = (len + 1) / 2;
            for (int w = 0; w < nw; w++) begin
                l = (w == nw - 1);
                d[7:0]  = msg[2*w];
                d[15:8] = (2*w + 1 < len) ? msg[2*w+1] : 8'h00;
                k = (!l || 2*w + 1 < len) ? 2'b11 : 2'b01;
                u = (w == 0) ? mode : mode + 2'd1;
                push(d, k, u, l);
            end
        end
        idle_in();
    endtask

    task automatic wait_blocks(input int n);
        int c;
        c = 0;
        while (blks.size() < n && c < 400) begin
            @(negedge ACLK);
            c++;
        end
        if (blks.size() < n) begin
            checks++; errors++;
            $display("FAIL block_timeout got %0d blocks required %0d", blks.size(), n);
        end
        repeat (5) @(negedge ACLK);
    endtask

    task automatic test_reset();
        ARESET = 1'b1;
        s_tdata = '0; s_tkeep = '0; s_tuser = '0; s_tlast = 0; s_tvalid = 0;
        blk_ready = 1'b1; dig_data = '0; dig_mode = '0; dig_valid = 0;
        m_tready = 1'b1;
        x_tdata = '0; x_tkeep = '0; x_dig_data = '0; x_dig_mode = '0;
        x_dig_valid = 0; x_m_tready = 1'b1;
        repeat (3) @(negedge ACLK);
        checks++;
        if ({s_tready, blk_valid, blk_first, blk_last, dig_ready, m_tvalid, m_tlast} !== 7'd0) begin
            errors++;
            $display("FAIL reset_ctrl got %b required 0000000",
                     {s_tready, blk_valid, blk_first, blk_last, dig_ready, m_tvalid, m_tlast});
        end
        checks++;
        if ({m_tkeep, m_tdata} !== 18'd0 || blk_data !== '0) begin
            errors++;
            $display("FAIL reset_data keep=%b tdata=%h blk_nonzero=%0b required 0",
                     m_tkeep, m_tdata, |blk_data);
        end
        ARESET = 1'b0;
        @(negedge ACLK);
        checks++;
        if ({s_tready, dig_ready, x_tready, x_dig_ready} !== 4'b1111) begin
            errors++;
            $display("FAIL reset_release ready got %b required 1111",
                     {s_tready, dig_ready, x_tready, x_dig_ready});
        end
    endtask

    task automatic test_empty();
        blk_t b;
        logic [1151:0] e;
        int i;
        blks.delete();
        send_msg(0, 2'd1);
        wait_blocks(1);
        checks++;
        if (blks.size() !== 1) begin
            errors++;
            $display("FAIL empty_count got %0d required 1", blks.size());
        end
        if (blks.size() > 0) begin
            b = blks[0];
            e = exp_block(0, 136, 1);
            checks++;
            if (b.data !== e) begin
                errors++; i = first_diff(b.data, e);
                $display("FAIL empty_data byte %0d got %h required %h",
                         i, b.data[8*i +: 8], e[8*i +: 8]);
            end
            checks++;
            if ({b.mode, b.first, b.last} !== {2'd1, 1'b1, 1'b1}) begin
                errors++;
                $display("FAIL empty_flags mode/first/last got %b required 0111",
                         {b.mode, b.first, b.last});
            end
        end
    endtask

    task automatic test_abc();
        blk_t b;
        logic [1151:0] e;
        int i;
        blks.delete();
        msg[0] = 8'h61; msg[1] = 8'h62; msg[2] = 8'h63;
        send_msg(3, 2'd0);
        wait_blocks(1);
        checks++;
        if (blks.size() !== 1) begin
            errors++;
            $display("FAIL abc_count got %0d required 1", blks.size());
        end
        if (blks.size() > 0) begin
            b = blks[0];
            e = exp_block(3, 144, 1);
            checks++;
            if (b.data !== e) begin
                errors++; i = first_diff(b.data, e);
                $display("FAIL abc_data byte %0d got %h required %h",
                         i, b.data[8*i +: 8], e[8*i +: 8]);
            end
            checks++;
            if ({b.mode, b.first, b.last} !== {2'd0, 1'b1, 1'b1}) begin
                errors++;
                $display("FAIL abc_flags mode/first/last got %b required 0011",
                         {b.mode, b.first, b.last});
            end
        end
    endtask

    task automatic test_135();
        blk_t b;
        logic [1151:0] e;
        int i;
        blks.delete();
        for (int j = 0; j < 144; j++) msg[j] = 8'(j * 7 + 3);
        send_msg(135, 2'd1);
        wait_blocks(1);
        checks++;
        if (blks.size() !== 1) begin
            errors++;
            $display("FAIL m135_count got %0d required 1", blks.size());
        end
        if (blks.size() > 0) begin
            b = blks[0];
            e = exp_block(135, 136, 1);
            checks++;
            if (b.data !== e) begin
                errors++; i = first_diff(b.data, e);
                $display("FAIL m135_data byte %0d got %h required %h",
                         i, b.data[8*i +: 8], e[8*i +: 8]);
            end
            checks++;
            if (b.data[8*135 +: 8] !== 8'h86) begin
                errors++;
                $display("FAIL m135_byte135 got %h required 86", b.data[8*135 +: 8]);
            end
            checks++;
            if ({b.mode, b.first, b.last} !== {2'd1, 1'b1, 1'b1}) begin
                errors++;
                $display("FAIL m135_flags got %b required 0111", {b.mode, b.first, b.last});
            end
        end
    endtask

    task automatic test_136();
        blk_t a, b;
        logic [1151:0] e;
        int i;
        blks.delete();
        for (int j = 0; j < 144; j++) msg[j] = 8'(j * 13 + 1);
        send_msg(136, 2'd1);
        wait_blocks(2);
        checks++;
        if (blks.size() !== 2) begin
            errors++;
            $display("FAIL m136_count got %0d required 2", blks.size());
        end
        if (blks.size() > 1) begin
            a = blks[0];
            b = blks[1];
            e = exp_block(136, 136, 0);
            checks++;
            if (a.data !== e) begin
                errors++; i = first_diff(a.data, e);
                $display("FAIL m136_a_data byte %0d got %h required %h",
                         i, a.data[8*i +: 8], e[8*i +: 8]);
            end
            checks++;
            if ({a.mode, a.first, a.last} !== {2'd1, 1'b1, 1'b0}) begin
                errors++;
                $display("FAIL m136_a_flags got %b required 0110", {a.mode, a.first, a.last});
            end
            e = exp_block(0, 136, 1);
            checks++;
            if (b.data !== e) begin
                errors++; i = first_diff(b.data, e);
                $display("FAIL m136_b_data byte %0d got %h required %h",
                         i, b.data[8*i +: 8], e[8*i +: 8]);
            end
            checks++;
            if ({b.mode, b.first, b.last} !== {2'd1, 1'b0, 1'b1}) begin
                errors++;
                $display("FAIL m136_b_flags got %b required 0101", {b.mode, b.first, b.last});
            end
        end
    endtask

    task automatic test_backpressure();
        logic [1151:0] e;
        int c;
        blks.delete();
        blk_ready = 1'b0;
        msg[0] = 8'h31; msg[1] = 8'h32;
        e = exp_block(2, 104, 1);
        send_msg(2, 2'd2);
        c = 0;
        while (!blk_valid && c < 50) begin
            @(negedge ACLK);
            c++;
        end
        checks++;
        if (!blk_valid) begin
            errors++;
            $display("FAIL bp_valid_timeout blk_valid=%0b required 1", blk_valid);
        end
        for (int k = 0; k < 10; k++) begin
            @(negedge ACLK);
            checks++;
            if (s_tready !== 1'b0 || blk_valid !== 1'b1 || blk_data !== e
                || blk_mode !== 2'd2) begin
                errors++;
                $display("FAIL bp_hold cycle %0d s_tready=%0b valid=%0b data_ok=%0b required 0/1/1",
                         k, s_tready, blk_valid, blk_data === e);
            end
        end
        blk_ready = 1'b1;
        #1;
        checks++;
        if (s_tready !== 1'b0) begin
            errors++;
            $display("FAIL bp_comb_ready s_tready=%0b required 0", s_tready);
        end
        wait_blocks(1);
        checks++;
        if (blks.size() !== 1 || blks[0].data !== e) begin
            errors++;
            $display("FAIL bp_block count=%0d required 1 with padded data", blks.size());
        end
    endtask

    task automatic test_digest16();
        logic [511:0] dg;
        int c;
        for (int j = 0; j < 64; j++) dg[8*j +: 8] = 8'(j) ^ 8'h5a;
        bd.delete(); bk.delete(); bl.delete();
        m_tready = 1'b0;
        c = 0;
        @(negedge ACLK);
        while (!dig_ready && c < 50) begin
            @(negedge ACLK);
            c++;
        end
        dig_data = dg; dig_mode = 2'd3; dig_valid = 1'b1;
        @(posedge ACLK);
        @(negedge ACLK);
        dig_valid = 1'b0;
        c = 0;
        while (bd.size() < 32 && c < 200) begin
            if (m_tvalid) begin
                checks++;
                if (m_tdata !== dg[16*bd.size() +: 16]) begin
                    errors++;
                    $display("FAIL dig16_present beat %0d got %h required %h",
                             bd.size(), m_tdata, dg[16*bd.size() +: 16]);
                end
            end
            m_tready = ~m_tready;
            @(negedge ACLK);
            c++;
        end
        checks++;
        if (bd.size() !== 32) begin
            errors++;
            $display("FAIL dig16_count got %0d required 32", bd.size());
        end
        checks++;
        if (dig_ready !== 1'b1 || m_tvalid !== 1'b0) begin
            errors++;
            $display("FAIL dig16_drain dig_ready=%0b m_tvalid=%0b required 1/0",
                     dig_ready, m_tvalid);
        end
        for (int j = 0; j < bd.size(); j++) begin
            checks++;
            if (bd[j] !== dg[16*j +: 16] || bk[j] !== 2'b11 || bl[j] !== (j == 31)) begin
                errors++;
                $display("FAIL dig16_beat %0d got %h/%b/%b required %h/11/%0b",
                         j, bd[j], bk[j], bl[j], dg[16*j +: 16], j == 31);
            end
        end
        m_tready = 1'b1;
    endtask

    task automatic test_digest64();
        logic [511:0] dg;
        logic [7:0] ek;
        int c;
        for (int j = 0; j < 64; j++) dg[8*j +: 8] = 8'(j * 3 + 17);
        xd.delete(); xk.delete(); xl.delete();
        @(negedge ACLK);
        x_dig_data = dg; x_dig_mode = 2'd0; x_dig_valid = 1'b1;
        @(posedge ACLK);
        @(negedge ACLK);
        x_dig_valid = 1'b0;
        c = 0;
        while (xd.size() < 4 && c < 50) begin
            @(negedge ACLK);
            c++;
        end
        repeat (3) @(negedge ACLK);
        checks++;
        if (xd.size() !== 4) begin
            errors++;
            $display("FAIL dig64_count got %0d required 4", xd.size());
        end
        for (int j = 0; j < xd.size(); j++) begin
            ek = (j == 3) ? 8'h0f : 8'hff;
            checks++;
            if (xd[j] !== dg[64*j +: 64] || xk[j] !== ek || xl[j] !== (j == 3)) begin
                errors++;
                $display("FAIL dig64_beat %0d got %h/%h/%b required %h/%h/%0b",
                         j, xd[j], xk[j], xl[j], dg[64*j +: 64], ek, j == 3);
            end
        end
    endtask

    task automatic test_reset_mid();
        blk_t b;
        logic [1151:0] e;
        int i;
        for (int w = 0; w < 20; w++) push(16'(w * 257 + 5), 2'b11, 2'd1, 1'b0);
        @(negedge ACLK);
        s_tvalid = 1'b0;
        ARESET = 1'b1;
        @(negedge ACLK);
        ARESET = 1'b0;
        blks.delete();
        repeat (2) @(negedge ACLK);
        msg[0] = 8'h61; msg[1] = 8'h62; msg[2] = 8'h63;
        send_msg(3, 2'd0);
        wait_blocks(1);
        checks++;
        if (blks.size() !== 1) begin
            errors++;
            $display("FAIL rmid_count got %0d required 1", blks.size());
        end
        if (blks.size() > 0) begin
            b = blks[0];
            e = exp_block(3, 144, 1);
            checks++;
            if (b.data !== e) begin
                errors++; i = first_diff(b.data, e);
                $display("FAIL rmid_data byte %0d got %h required %h",
                         i, b.data[8*i +: 8], e[8*i +: 8]);
            end
            checks++;
            if ({b.mode, b.first, b.last} !== {2'd0, 1'b1, 1'b1}) begin
                errors++;
                $display("FAIL rmid_flags got %b required 0011", {b.mode, b.first, b.last});
            end
        end
    endtask

    initial begin
        test_reset();
        test_empty();
        test_abc();
        test_135();
        test_136();
        test_backpressure();
        test_digest16();
        test_digest64();
        test_reset_mid();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog simulation did not complete");
        $fatal(1);
    end

endmodule

// File: doc/sha3_axis_frontend.md
# sha3_axis_frontend

Parametrised AXI-Stream front end for the SHA3 Keccak core. It packs byte-granular input words into rate-sized blocks and applies SHA3 padding (0x06…0x80) in hardware, so the driver no longer signals the last block by hand. It hands blocks to the permutation core over a valid/ready handshake. It also serialises the core's digest back out as an AXI-Stream packet, with full backpressure on every interface.

## Interface
- WIDTH, 16: stream data width in bits; legal values are 8, 16, 32 and 64, each dividing every rate.
- KW, WIDTH/8: keep width; derived, not overridable.
- ACLK  in  1  clock
- ARESET  in  1  asynchronous reset, active-high
- s_tdata  in  WIDTH  message word; byte i maps to bits [8i+7:8i]
- s_tkeep  in  KW  valid bytes; contiguous from LSB; honoured only when s_tlast=1
- s_tuser  in  2  mode: 0=SHA3-224, 1=256, 2=384, 3=512; sampled on the first word of a message
- s_tlast  in  1  final word of message
- s_tvalid / s_tready  in / out  1  input handshake
- blk_data  out  1152  rate block; word k occupies [k*WIDTH +: WIDTH]; bits at and above the rate are 0
- blk_mode  out  2  mode of the block
- blk_first  out  1  first block of the message (core clears its state)
- blk_last  out  1  final padded block (core produces the digest)
- blk_valid / blk_ready  out / in  1  block handshake
- dig_data  in  512  digest, LSB-first byte order
- dig_mode  in  2  mode of the digest
- dig_valid / dig_ready  in / out  1  digest handshake
- m_tdata  out  WIDTH  digest word
- m_tkeep  out  KW  valid bytes of the digest word
- m_tlast  out  1  final digest word
- m_tvalid / m_tready  out / in  1  output handshake

## Operation
- Rate in bytes: R = 144, 136, 104 or 72 for modes 0 to 3. Rate in words: RW = R*8/WIDTH.
- Absorb FSM states: IDLE, FILL, PAD, SEND.
  - IDLE: s_tready=1. First accepted word latches the mode, clears the buffer, sets first_pend=1, then goes to FILL (or to PAD/SEND per the rules below).
  - FILL: s_tready=1, one word per cycle at index widx.
    - When widx reaches RW-1 and the word is accepted without tlast, go to SEND with last=0.
  - Rules on an accepted tlast word:
    - Let b = widx*KW + popcount(s_tkeep) be the byte position after the last message byte.
    - If b < R: go to PAD.
    - If b == R: go to SEND with last=0 and set pad_pend.
  - PAD (1 cycle, s_tready=0): zero all bytes ≥ b, OR 0x06 into byte b, then OR 0x80 into byte R-1. When b = R-1 the byte becomes 0x86. Then go to SEND with last=1.
  - SEND: blk_valid=1; blk_data, blk_mode, blk_first and blk_last are held stable until blk_ready.
    - On handshake: clear first_pend.
    - If pad_pend: clear the buffer, set b=0, go to PAD.
    - Else if the block was last: go to IDLE.
    - Else: go to FILL with widx=0.
- Empty message: tlast with tkeep=0 in IDLE gives b=0, so the output is a single padding-only block.
- Mode changes on s_tuser after the first word are ignored.
- Digest serialiser:
  - dig_ready=1 only when empty. Captures dig_data and dig_mode on handshake.
  - Emits N = ceil(D/WIDTH) beats, with D = 224, 256, 384 or 512 bits by mode. Beat j carries dig_data[j*WIDTH +: WIDTH].
  - m_tkeep is all-ones except on the final beat when D mod WIDTH ≠ 0. For 224 bits with WIDTH=64 the final keep is 0x0F.
  - m_tlast is asserted on beat N-1 only.

## Timing
- Reset values: s_tready=0, blk_valid=0, blk_first=0, blk_last=0, blk_data=0, dig_ready=0, m_tvalid=0, m_tlast=0, m_tkeep=0, m_tdata=0.
  - s_tready and dig_ready rise in the first cycle after ARESET deasserts.
- ARESET mid-operation discards any partial block and any undelivered digest beats. No block for that message is ever issued. The next message starts with blk_first=1.
- blk_valid rises on the cycle after the accepted word that fills the block, or 1 cycle later when going through PAD.
- Minimum absorb cost per block: RW input cycles, plus 1 SEND cycle, plus 1 PAD cycle on the final block.
- No combinational path from blk_ready to s_tready. s_tready is decoded from registered state.
- m_tvalid rises the cycle after the digest capture. Data is stable while m_tvalid=1 and m_tready=0.
- dig_ready returns to 1 the cycle after the final beat is accepted. A new digest is never captured in the same cycle as the final beat.
- Absorb and serialiser run independently; simultaneous activity is legal.

## Structure
- Package sha3_pkg holds:
  - the mode encoding enum
  - the rate-bytes and digest-bits lookup functions
  - the pad constants 0x06 and 0x80
  - MAX_RATE = 1152
- One sub-module, sha3_digest_serializer, contains the digest handshake, the beat counter and the keep generation.

## Test plan
- Empty message, mode 1, WIDTH=16: one beat with tlast=1, tkeep=00 → one block with byte0=0x06, byte135=0x80, all else 0, first=last=1.
- "abc", mode 0: beats 0x6261/keep 11, then 0x0063/keep 01/tlast → bytes 61 62 63 06, zeros, byte143=0x80, single block.
- 135-byte message, mode 1: final keep 01 at word 67 → byte135=0x86, single block.
- 136-byte message, mode 1 → block A with first=1, last=0, all message bytes; then block B with first=0, last=1, byte0=0x06, byte135=0x80, remaining bytes 0.
- Backpressure:
  - Hold blk_ready=0 for 10 cycles → s_tready stays 0 and blk_data is stable.
  - Mode 3 digest with m_tready toggling every cycle → 32 beats in order, tlast on beat 31.
- WIDTH=64, mode 0 digest → 4 beats, final m_tkeep=0x0F.
- Reset mid-operation: ARESET pulse after 20 words, then "abc" → only the "abc" block appears, with first=1.
